// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer: arbitrates entry/exit requests and sequences the shared barrier through open, pass and close.
module parking_gate_sequencer #(
  parameter int OPEN_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_req,
  input  logic entry_is_uni,
  input  logic exit_req,
  input  logic exit_is_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  input  logic pass_sensor,
  output logic entry_grant,
  output logic exit_grant,
  output logic entry_reject,
  output logic gate_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic timeout,
  output logic busy
);
  localparam int MAXC = OPEN_CYCLES > PASS_TIMEOUT ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYCLES - 1);
  localparam logic [CW-1:0] PASS_LOAD = CW'(PASS_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dir, dir_n, uni, uni_n, last_exit, last_n, blocked, blocked_n;
  logic eg, xg, er, ce, cx, to;
  logic ent_ok, sel_exit, sel_entry, space_ok;
  // dir=1 means the latched passage is an exit; ties go opposite the last served side
  assign ent_ok    = entry_req & ~blocked;
  assign sel_exit  = exit_req & (~ent_ok | ~last_exit);
  assign sel_entry = ent_ok & ~sel_exit;
  assign space_ok  = entry_is_uni ? uni_is_vacated_space : is_vacated_space;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt != '0 ? cnt - 1'b1 : cnt;
    dir_n     = dir;
    uni_n     = uni;
    last_n    = last_exit;
    blocked_n = blocked & entry_req;
    eg = 1'b0;
    xg = 1'b0;
    er = 1'b0;
    ce = 1'b0;
    cx = 1'b0;
    to = 1'b0;
    case (state)
      IDLE: begin
        if (sel_exit || (sel_entry && space_ok)) begin
          xg      = sel_exit;
          eg      = ~sel_exit;
          dir_n   = sel_exit;
          last_n  = sel_exit;
          uni_n   = sel_exit ? exit_is_uni : entry_is_uni;
          cnt_n   = OPEN_LOAD;
          state_n = OPENING;
        end else if (sel_entry) begin
          er        = 1'b1;
          blocked_n = 1'b1;
        end
      end
      OPENING: begin
        if (cnt == '0) begin
          cnt_n   = PASS_LOAD;
          state_n = WAIT_PASS;
        end
      end
      WAIT_PASS: begin
        if (pass_sensor || cnt == '0) begin
          ce      = pass_sensor & ~dir;
          cx      = pass_sensor & dir;
          to      = ~pass_sensor;
          cnt_n   = OPEN_LOAD;
          state_n = CLOSING;
        end
      end
      default: state_n = (cnt == '0 && !pass_sensor) ? IDLE : CLOSING;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      dir                <= 1'b0;
      uni                <= 1'b0;
      last_exit          <= 1'b0;
      blocked            <= 1'b0;
      entry_grant        <= 1'b0;
      exit_grant         <= 1'b0;
      entry_reject       <= 1'b0;
      gate_open          <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      timeout            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      dir                <= dir_n;
      uni                <= uni_n;
      last_exit          <= last_n;
      blocked            <= blocked_n;
      entry_grant        <= eg;
      exit_grant         <= xg;
      entry_reject       <= er;
      gate_open          <= state == OPENING || state == WAIT_PASS;
      car_entered        <= ce;
      is_uni_car_entered <= ce & uni;
      car_exited         <= cx;
      is_uni_car_exited  <= cx & uni;
      timeout            <= to;
      busy               <= state != IDLE;
    end
  end
endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb_parking_gate_sequencer: vector table, directed corner sequences and random traffic against a phase/elapsed-time model.
module tb_parking_gate_sequencer;
  localparam int OC = 4;
  localparam int PT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_req = 0, entry_is_uni = 0, exit_req = 0, exit_is_uni = 0;
  logic uni_vac = 0, vac = 0, pass_sensor = 0;
  logic entry_grant, exit_grant, entry_reject, gate_open, car_entered, is_uni_car_entered;
  logic car_exited, is_uni_car_exited, timeout, busy;
  logic [9:0] outs;
  int checks = 0, errors = 0;
  int m_ph = 0, m_t = 0;
  bit m_dir = 0, m_uni = 0, m_last_exit = 0, m_blk = 0;
  typedef struct packed {
    logic [6:0] in;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[13];
  always #5 clk = ~clk;
  parking_gate_sequencer #(.OPEN_CYCLES(OC), .PASS_TIMEOUT(PT)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .entry_is_uni(entry_is_uni),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni), .uni_is_vacated_space(uni_vac),
    .is_vacated_space(vac), .pass_sensor(pass_sensor), .entry_grant(entry_grant),
    .exit_grant(exit_grant), .entry_reject(entry_reject), .gate_open(gate_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .timeout(timeout), .busy(busy)
  );
  assign outs = {entry_grant, exit_grant, entry_reject, gate_open, car_entered,
                 is_uni_car_entered, car_exited, is_uni_car_exited, timeout, busy};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  // phases: 0 idle, 1 opening, 2 waiting for the car, 3 closing; m_t counts cycles spent in the phase
  task automatic model(output logic [9:0] e);
    bit ent, want_exit, nblk;
    e = '0;
    if (rst) begin
      m_ph = 0; m_t = 0; m_dir = 0; m_uni = 0; m_last_exit = 0; m_blk = 0;
      return;
    end
    e[6] = (m_ph == 1 || m_ph == 2);
    e[0] = m_ph != 0;
    nblk = m_blk && entry_req;
    m_t++;
    case (m_ph)
      0: begin
        ent = entry_req && !m_blk;
        want_exit = exit_req && (!ent || !m_last_exit);
        if (want_exit) begin
          e[8] = 1; m_dir = 1; m_uni = exit_is_uni; m_last_exit = 1; m_ph = 1; m_t = 0;
        end else if (ent && (entry_is_uni ? uni_vac : vac)) begin
          e[9] = 1; m_dir = 0; m_uni = entry_is_uni; m_last_exit = 0; m_ph = 1; m_t = 0;
        end else if (ent) begin
          e[7] = 1; nblk = 1;
        end
      end
      1: if (m_t == OC) begin m_ph = 2; m_t = 0; end
      2: begin
        if (pass_sensor) begin
          e[5] = !m_dir; e[4] = !m_dir && m_uni; e[3] = m_dir; e[2] = m_dir && m_uni;
          m_ph = 3; m_t = 0;
        end else if (m_t == PT) begin
          e[1] = 1; m_ph = 3; m_t = 0;
        end
      end
      default: if (m_t >= OC && !pass_sensor) begin m_ph = 0; m_t = 0; end
    endcase
    m_blk = nblk;
  endtask
  task automatic step(input string name);
    logic [9:0] e;
    model(e);
    @(posedge clk);
    #1;
    chk(name, 32'(outs), 32'(e));
  endtask
  task automatic set_in(input logic [6:0] v);
    {entry_req, entry_is_uni, exit_req, exit_is_uni, uni_vac, vac, pass_sensor} = v;
  endtask
  initial begin
    int n, k, steps_to;
    string order;
    // inputs {entry_req, entry_is_uni, exit_req, exit_is_uni, uni_vac, vac, pass_sensor}
    // outputs {eg, xg, er, gate, ce, uce, cx, ucx, timeout, busy}
    tbl[0] = '{7'b1100100, 10'b1000000000};
    for (int i = 1; i <= 6; i++) tbl[i] = '{7'b0100100, 10'b0001000001};
    tbl[7]  = '{7'b0100101, 10'b0001110001};
    tbl[8]  = '{7'b0100101, 10'b0000000001};
    tbl[9]  = '{7'b0100100, 10'b0000000001};
    tbl[10] = '{7'b0100100, 10'b0000000001};
    tbl[11] = '{7'b0100100, 10'b0000000001};
    tbl[12] = '{7'b0100100, 10'b0000000000};
    rst = 1;
    step("reset0");
    step("reset1");
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].in);
      step("entry_model");
      chk($sformatf("entry_vec%0d", i), 32'(outs), 32'(tbl[i].exp));
    end
    set_in(7'b1000000);
    n = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      step("reject_model");
      n += entry_reject;
      k += gate_open | entry_grant;
    end
    chk("reject_count", n, 1);
    chk("reject_no_grant_gate", k, 0);
    entry_req = 0;
    step("reject_drop");
    vac = 1; entry_req = 1;
    step("reject_retry");
    chk("reject_retry_grant", entry_grant, 1);
    entry_req = 0;
    for (int i = 0; i < 12; i++) begin
      pass_sensor = (m_ph == 2);
      step("retry_pass");
    end
    pass_sensor = 0;
    step("retry_idle");
    entry_req = 1; exit_req = 1; order = "";
    for (int i = 0; i < 60; i++) begin
      pass_sensor = (m_ph == 2);
      step("tie_model");
      if (exit_grant) order = {order, "X"};
      if (entry_grant) order = {order, "E"};
    end
    chk("tie_order", 32'(order.substr(0, 3) == "XEXE"), 1);
    entry_req = 0; exit_req = 0; pass_sensor = 0;
    for (int i = 0; i < 15; i++) step("tie_drain");
    exit_req = 1;
    step("to_grant");
    chk("to_exit_grant", exit_grant, 1);
    exit_req = 0; steps_to = -1; n = 0;
    for (int i = 1; i <= 40; i++) begin
      step("to_model");
      if (timeout && steps_to < 0) steps_to = i;
      n += car_exited;
    end
    chk("to_latency", steps_to, 20);
    chk("to_no_exit_pulse", n, 0);
    entry_req = 1; entry_is_uni = 0;
    step("rm_grant");
    entry_req = 0;
    for (int i = 0; i < 6; i++) step("rm_run");
    chk("rm_in_wait", m_ph, 2);
    rst = 1;
    step("rm_reset");
    chk("rm_gate_busy", {gate_open, busy, car_entered, car_exited}, 0);
    rst = 0; entry_req = 1; exit_req = 1;
    step("rm_tie");
    chk("rm_exit_first", {exit_grant, entry_grant}, 2'b10);
    entry_req = 0; exit_req = 0;
    for (int i = 0; i < 4; i++) step("rm_open");
    pass_sensor = 1;
    for (int i = 0; i < 12; i++) step("rm_close");
    pass_sensor = 0;
    for (int i = 0; i < 6; i++) step("rm_drain");
    entry_req = 1; entry_is_uni = 1; uni_vac = 1;
    step("ov_grant");
    entry_req = 0; n = 0; k = 0;
    for (int i = 0; i < 30 && k < 10; i++) begin
      if (m_ph == 2 || k > 0) begin pass_sensor = 1; k++; end
      step("ov_model");
      n += car_entered;
    end
    pass_sensor = 0;
    for (int i = 0; i < 8; i++) begin
      step("ov_tail");
      n += car_entered;
    end
    chk("ov_single_pulse", n, 1);
    chk("ov_idle", busy, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      entry_req = ($urandom_range(3) != 0);
      entry_is_uni = $urandom_range(1);
      exit_req = ($urandom_range(2) == 0);
      exit_is_uni = $urandom_range(1);
      uni_vac = ($urandom_range(3) != 0);
      vac = $urandom_range(1);
      pass_sensor = ($urandom_range(5) == 0);
      step("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
- Sequences the single shared barrier gate in front of ParkingSystem.
- Arbitrates between an entry requester and an exit requester.
- Checks capacity flags from ParkingSystem before admitting an entry.
- Runs an open / wait-for-pass / close cycle and emits exactly one car_entered or car_exited pulse per completed passage, so ParkingSystem counters change only on confirmed transits.

Parameters:
- OPEN_CYCLES, 4, cycles the barrier takes to open and, separately, to close (>=1).
- PASS_TIMEOUT, 16, max cycles in WAIT_PASS before the passage is aborted (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- entry_req  input  1  level request from the entry lane
- entry_is_uni  input  1  entering car is a university car; sampled at grant
- exit_req  input  1  level request from the exit lane
- exit_is_uni  input  1  exiting car is a university car; sampled at grant
- uni_is_vacated_space  input  1  ParkingSystem: university space available
- is_vacated_space  input  1  ParkingSystem: free space available
- pass_sensor  input  1  loop sensor under the barrier, high while a car is over it
- entry_grant  output  1  1-cycle pulse: entry request accepted
- exit_grant  output  1  1-cycle pulse: exit request accepted
- entry_reject  output  1  1-cycle pulse: entry refused, no space for that car type
- gate_open  output  1  barrier drive; high in OPENING and WAIT_PASS
- car_entered  output  1  1-cycle pulse to ParkingSystem
- is_uni_car_entered  output  1  valid in the cycle car_entered is high
- car_exited  output  1  1-cycle pulse to ParkingSystem
- is_uni_car_exited  output  1  valid in the cycle car_exited is high
- timeout  output  1  1-cycle pulse: passage aborted, no counter update
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, takes priority in any state):
  - State goes to IDLE.
  - All outputs are 0 on the next edge. If the gate was open, gate_open drops with no pulse.
  - Latched direction and uni flag are cleared.
  - last_served = ENTRY, so exit wins the first tie.
  - entry_blocked = 0.
- States: IDLE, OPENING, WAIT_PASS, CLOSING.
- IDLE arbitration, once per cycle:
  - An entry is eligible when entry_req=1 and entry_blocked=0.
  - Only one requester eligible: it is selected.
  - Both eligible: the direction opposite last_served is selected.
- Capacity check for a selected entry:
  - The required flag is uni_is_vacated_space when entry_is_uni=1, otherwise is_vacated_space.
  - Flag low: pulse entry_reject, set entry_blocked, stay in IDLE, leave last_served unchanged.
  - If exit_req is also high in that cycle, exit is considered the next cycle.
  - entry_blocked clears in the first cycle entry_req is sampled 0.
- Accept:
  - Pulse entry_grant or exit_grant in the same cycle as the selection decision.
  - Latch direction and the is_uni input; set last_served.
  - Load the counter with OPEN_CYCLES-1 and go to OPENING.
- OPENING:
  - gate_open=1; the counter decrements each cycle.
  - At 0: load PASS_TIMEOUT-1 and go to WAIT_PASS.
  - Duration is exactly OPEN_CYCLES cycles.
- WAIT_PASS:
  - gate_open=1.
  - On the first cycle pass_sensor is high, pulse car_entered or car_exited (per latched direction) for 1 cycle. is_uni_car_* equals the latched flag in that cycle. Go to CLOSING.
  - If the counter reaches 0 with pass_sensor still low, pulse timeout (no car_* pulse) and go to CLOSING.
  - If pass_sensor rises in the final count cycle, the passage wins and there is no timeout.
- CLOSING:
  - gate_open=0; the counter runs OPEN_CYCLES cycles.
  - Exits to IDLE only when the counter is 0 and pass_sensor=0. If the car is still over the loop, hold CLOSING until it clears.
  - Requests are ignored during this state and are not queued.
- Capacity flags are sampled only at the IDLE decision. Changes during a passage do not abort it.
- Requests arriving while busy stay pending as levels and are arbitrated on return to IDLE, at the earliest 1 cycle after CLOSING ends.
- Requesters must drop req after a grant or reject. A req still high on return to IDLE is treated as a new request.
- At most one of entry_grant, exit_grant, entry_reject is high per cycle.
- At most one of car_entered, car_exited is high per cycle.
- Output timing:
  - All outputs are registered.
  - Pulses rise on the edge that enters the decision cycle and fall on the next edge.
  - Grant to first gate_open=1 is 1 cycle.

Test Plan:
- Entry path:
  - Stimulus: rst 2 cycles, then entry_req=1, entry_is_uni=1, uni_is_vacated_space=1; pass_sensor high 3 cycles into WAIT_PASS, for 2 cycles.
  - Response: entry_grant pulse; gate_open high 4 cycles (OPENING) plus 3 cycles (WAIT_PASS); one car_entered with is_uni_car_entered=1; CLOSING for 4 cycles; back in IDLE with busy=0.
- Reject path:
  - Stimulus: entry_req=1, entry_is_uni=0, is_vacated_space=0, held 10 cycles.
  - Response: exactly one entry_reject; no grant; gate_open stays 0.
  - Follow-up: drop req, set is_vacated_space=1, raise req. Response: entry_grant.
- Tie arbitration:
  - Stimulus: after reset, entry_req and exit_req both high continuously; each passage completed by pass_sensor.
  - Response: grant order is exit, entry, exit, entry; car_exited and car_entered pulses alternate.
- Timeout:
  - Stimulus: exit granted, pass_sensor held 0.
  - Response: timeout pulse exactly 16 cycles after WAIT_PASS entry; no car_exited; IDLE after 4 CLOSING cycles.
- Reset mid-operation:
  - Stimulus: assert rst in the 2nd WAIT_PASS cycle.
  - Response: next cycle gate_open=0, busy=0, no car_* pulse; after release with both req high, exit is granted first.
- Sensor overlap:
  - Stimulus: pass_sensor held high 10 cycles from the passage.
  - Response: single car_entered pulse; CLOSING persists until sensor low; no second pulse.
